// File: rtl/axi_error_slave.sv
// AXI4 burst-capable slave that completes every transaction with a fixed error
// response; write and read channels run as two independent state machines.
module axi_error_slave #(
    parameter int         C_AXI_ID_WIDTH   = 4,
    parameter int         C_AXI_DATA_WIDTH = 32,
    parameter logic [1:0] OPT_RESP         = 2'b11,
    parameter logic       OPT_LOWPOWER     = 1'b0
) (
    input  logic                        S_AXI_ACLK,
    input  logic                        i_reset,
    // Write address / data / response
    input  logic                        S_AXI_AWVALID,
    output logic                        S_AXI_AWREADY,
    input  logic [C_AXI_ID_WIDTH-1:0]   S_AXI_AWID,
    input  logic                        S_AXI_WVALID,
    output logic                        S_AXI_WREADY,
    input  logic                        S_AXI_WLAST,
    output logic                        S_AXI_BVALID,
    input  logic                        S_AXI_BREADY,
    output logic [C_AXI_ID_WIDTH-1:0]   S_AXI_BID,
    output logic [1:0]                  S_AXI_BRESP,
    // Read address / data
    input  logic                        S_AXI_ARVALID,
    output logic                        S_AXI_ARREADY,
    input  logic [C_AXI_ID_WIDTH-1:0]   S_AXI_ARID,
    input  logic [7:0]                  S_AXI_ARLEN,
    output logic                        S_AXI_RVALID,
    input  logic                        S_AXI_RREADY,
    output logic [C_AXI_ID_WIDTH-1:0]   S_AXI_RID,
    output logic [C_AXI_DATA_WIDTH-1:0] S_AXI_RDATA,
    output logic                        S_AXI_RLAST,
    output logic [1:0]                  S_AXI_RRESP
);

    localparam logic [1:0] W_IDLE = 2'd0;
    localparam logic [1:0] W_DATA = 2'd1;
    localparam logic [1:0] W_RESP = 2'd2;

    localparam logic [0:0] R_IDLE = 1'b0;
    localparam logic [0:0] R_DATA = 1'b1;

    logic [1:0]                w_state_q, w_state_d;
    logic                      awready_q, wready_q, bvalid_q;
    logic [C_AXI_ID_WIDTH-1:0] bid_q, bid_d;

    logic [0:0]                r_state_q, r_state_d;
    logic                      arready_q, rvalid_q;
    logic                      rlast_q, rlast_d;
    logic [C_AXI_ID_WIDTH-1:0] rid_q, rid_d;
    logic [7:0]                rcnt_q, rcnt_d;

    // ------------------------------------------------------------------
    // Write channel
    // ------------------------------------------------------------------
    // NOTE: every variable gets a default before the case so no latch is inferred.
    always_comb begin
        w_state_d = w_state_q;
        bid_d     = bid_q;
        case (w_state_q)
            W_IDLE: if (S_AXI_AWVALID && awready_q) begin
                w_state_d = W_DATA;
                bid_d     = S_AXI_AWID;
            end
            W_DATA: if (S_AXI_WVALID && wready_q && S_AXI_WLAST) begin
                w_state_d = W_RESP;
            end
            W_RESP: if (S_AXI_BREADY && bvalid_q) begin
                w_state_d = W_IDLE;
                if (OPT_LOWPOWER) bid_d = '0;
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    // Handshake outputs are registered copies of the next state, so they
    // stay low during reset and rise on the first clock after it.
    // NOTE: sequential state uses non-blocking assignments to avoid ordering races.
    always_ff @(posedge S_AXI_ACLK) begin
        if (i_reset) begin
            w_state_q <= W_IDLE;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bid_q     <= '0;
        end else begin
            w_state_q <= w_state_d;
            awready_q <= (w_state_d == W_IDLE);
            wready_q  <= (w_state_d == W_DATA);
            bvalid_q  <= (w_state_d == W_RESP);
            bid_q     <= bid_d;
        end
    end

    // ------------------------------------------------------------------
    // Read channel
    // ------------------------------------------------------------------
    always_comb begin
        r_state_d = r_state_q;
        rid_d     = rid_q;
        rcnt_d    = rcnt_q;
        rlast_d   = rlast_q;
        case (r_state_q)
            R_IDLE: if (S_AXI_ARVALID && arready_q) begin
                r_state_d = R_DATA;
                rid_d     = S_AXI_ARID;
                rcnt_d    = S_AXI_ARLEN;
                rlast_d   = (S_AXI_ARLEN == 8'd0);
            end
            R_DATA: if (S_AXI_RREADY && rvalid_q) begin
                // The counter is only decremented on non-final beats, so it
                // stops at zero and can never wrap.
                if (rlast_q) begin
                    r_state_d = R_IDLE;
                    rlast_d   = 1'b0;
                    if (OPT_LOWPOWER) rid_d = '0;
                end else begin
                    rcnt_d  = rcnt_q - 8'd1;
                    rlast_d = (rcnt_q == 8'd1);
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge S_AXI_ACLK) begin
        if (i_reset) begin
            r_state_q <= R_IDLE;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rlast_q   <= 1'b0;
            rid_q     <= '0;
            rcnt_q    <= 8'd0;
        end else begin
            r_state_q <= r_state_d;
            arready_q <= (r_state_d == R_IDLE);
            rvalid_q  <= (r_state_d == R_DATA);
            rlast_q   <= rlast_d;
            rid_q     <= rid_d;
            rcnt_q    <= rcnt_d;
        end
    end

    assign S_AXI_AWREADY = awready_q;
    assign S_AXI_WREADY  = wready_q;
    assign S_AXI_BVALID  = bvalid_q;
    assign S_AXI_BID     = bid_q;
    assign S_AXI_BRESP   = OPT_RESP;

    assign S_AXI_ARREADY = arready_q;
    assign S_AXI_RVALID  = rvalid_q;
    assign S_AXI_RID     = rid_q;
    assign S_AXI_RDATA   = '0;
    assign S_AXI_RLAST   = rlast_q;
    assign S_AXI_RRESP   = OPT_RESP;

endmodule

// File: tb/tb_axi_error_slave.sv
// Directed bench for axi_error_slave: inputs driven and outputs sampled on the
// falling edge; a handshake is predicted there and happens on the next rising edge.
module tb_axi_error_slave;

    localparam int IDW = 4;
    localparam int DW  = 32;

    logic           clk = 1'b0;
    logic           i_reset;
    logic           S_AXI_AWVALID, S_AXI_AWREADY;
    logic [IDW-1:0] S_AXI_AWID;
    logic           S_AXI_WVALID, S_AXI_WREADY, S_AXI_WLAST;
    logic           S_AXI_BVALID, S_AXI_BREADY;
    logic [IDW-1:0] S_AXI_BID;
    logic [1:0]     S_AXI_BRESP;
    logic           S_AXI_ARVALID, S_AXI_ARREADY;
    logic [IDW-1:0] S_AXI_ARID;
    logic [7:0]     S_AXI_ARLEN;
    logic           S_AXI_RVALID, S_AXI_RREADY;
    logic [IDW-1:0] S_AXI_RID;
    logic [DW-1:0]  S_AXI_RDATA;
    logic           S_AXI_RLAST;
    logic [1:0]     S_AXI_RRESP;

    int tests_run = 0;
    int failed    = 0;

    always #5 clk = ~clk;

    axi_error_slave #(
        .C_AXI_ID_WIDTH(IDW), .C_AXI_DATA_WIDTH(DW),
        .OPT_RESP(2'b11), .OPT_LOWPOWER(1'b0)
    ) dut (
        .S_AXI_ACLK(clk), .i_reset(i_reset),
        .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY), .S_AXI_AWID(S_AXI_AWID),
        .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY), .S_AXI_WLAST(S_AXI_WLAST),
        .S_AXI_BVALID(S_AXI_BVALID), .S_AXI_BREADY(S_AXI_BREADY), .S_AXI_BID(S_AXI_BID),
        .S_AXI_BRESP(S_AXI_BRESP),
        .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY), .S_AXI_ARID(S_AXI_ARID),
        .S_AXI_ARLEN(S_AXI_ARLEN),
        .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY), .S_AXI_RID(S_AXI_RID),
        .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RLAST(S_AXI_RLAST), .S_AXI_RRESP(S_AXI_RRESP)
    );

    task automatic test_reset();
        i_reset = 1'b1;
        {S_AXI_AWVALID, S_AXI_WVALID, S_AXI_WLAST, S_AXI_BREADY} = '0;
        {S_AXI_ARVALID, S_AXI_RREADY} = '0;
        S_AXI_AWID = '0; S_AXI_ARID = '0; S_AXI_ARLEN = '0;
        repeat (3) @(negedge clk);
        tests_run++;
        if ({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BVALID, S_AXI_ARREADY, S_AXI_RVALID,
             S_AXI_RLAST, S_AXI_BID, S_AXI_RID} !== '0) begin
            failed++; $display("FAIL reset_outputs: some output nonzero during reset, expected all 0");
        end
        i_reset = 1'b0;
        @(negedge clk);
        tests_run++;
        if ({S_AXI_AWREADY, S_AXI_ARREADY, S_AXI_WREADY, S_AXI_RVALID} !== 4'b1100) begin
            failed++; $display("FAIL reset_release: aw/ar/w/rvalid=%b expected 1100",
                {S_AXI_AWREADY, S_AXI_ARREADY, S_AXI_WREADY, S_AXI_RVALID});
        end
    endtask

    task automatic test_single_write();
        S_AXI_AWVALID = 1'b1; S_AXI_AWID = 4'd5;
        @(negedge clk);
        tests_run++;
        if ({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BVALID} !== 3'b010) begin
            failed++; $display("FAIL sw_wdata_phase: aw/w/b=%b expected 010",
                {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BVALID});
        end
        S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b1; S_AXI_WLAST = 1'b1; S_AXI_BREADY = 1'b1;
        @(negedge clk);
        tests_run++;
        if ({S_AXI_WREADY, S_AXI_BVALID} !== 2'b01) begin
            failed++; $display("FAIL sw_bvalid: w/b=%b expected 01", {S_AXI_WREADY, S_AXI_BVALID});
        end
        tests_run++;
        if (S_AXI_BID !== 4'd5 || S_AXI_BRESP !== 2'b11) begin
            failed++; $display("FAIL sw_bid_bresp: bid=%0d bresp=%b expected 5/11", S_AXI_BID, S_AXI_BRESP);
        end
        S_AXI_WVALID = 1'b0; S_AXI_WLAST = 1'b0;
        @(negedge clk);
        tests_run++;
        if ({S_AXI_BVALID, S_AXI_AWREADY} !== 2'b01) begin
            failed++; $display("FAIL sw_return_idle: b/aw=%b expected 01", {S_AXI_BVALID, S_AXI_AWREADY});
        end
        tests_run++;
        if (S_AXI_BID !== 4'd5) begin
            failed++; $display("FAIL sw_bid_hold: bid=%0d expected 5", S_AXI_BID);
        end
        S_AXI_BREADY = 1'b0;
    endtask

    task automatic test_read_burst();
        int beats = 0, gaps = 0, bad = 0;
        S_AXI_ARVALID = 1'b1; S_AXI_ARID = 4'd3; S_AXI_ARLEN = 8'd3; S_AXI_RREADY = 1'b1;
        for (int cyc = 0; cyc < 20; cyc++) begin
            @(negedge clk);
            S_AXI_ARVALID = 1'b0;
            if (S_AXI_RVALID) begin
                beats++;
                if (S_AXI_RID !== 4'd3 || S_AXI_RDATA !== '0 || S_AXI_RRESP !== 2'b11 ||
                    S_AXI_RLAST !== (beats == 4) || S_AXI_ARREADY !== 1'b0) bad++;
            end else if (beats > 0) begin
                if (beats < 4) gaps++;
                else break;
            end
        end
        tests_run++;
        if (beats !== 4) begin
            failed++; $display("FAIL rb_beats: got %0d beats expected 4", beats);
        end
        tests_run++;
        if (bad !== 0 || gaps !== 0) begin
            failed++; $display("FAIL rb_fields: %0d bad beats, %0d gaps, expected 0/0", bad, gaps);
        end
        tests_run++;
        if (S_AXI_ARREADY !== 1'b1) begin
            failed++; $display("FAIL rb_arready_back: arready=%b expected 1", S_AXI_ARREADY);
        end
    endtask

    task automatic test_long_read();
        int beats = 0, hold_err = 0, last_err = 0, id_err = 0;
        logic prev_stall = 1'b0, prev_last = 1'b0;
        logic [IDW-1:0] prev_id = '0;
        S_AXI_ARVALID = 1'b1; S_AXI_ARID = 4'hA; S_AXI_ARLEN = 8'd255; S_AXI_RREADY = 1'b0;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            @(negedge clk);
            S_AXI_ARVALID = 1'b0;
            if (prev_stall && (S_AXI_RVALID !== 1'b1 || S_AXI_RID !== prev_id || S_AXI_RLAST !== prev_last))
                hold_err++;
            S_AXI_RREADY = 1'($urandom_range(0, 1));
            if (S_AXI_RVALID) begin
                if (S_AXI_RID !== 4'hA) id_err++;
                if (S_AXI_RREADY) begin
                    if (S_AXI_RLAST !== (beats == 255)) last_err++;
                    beats++;
                end
                prev_stall = !S_AXI_RREADY;
                prev_id    = S_AXI_RID;
                prev_last  = S_AXI_RLAST;
            end else begin
                prev_stall = 1'b0;
                if (beats > 0) break;
            end
        end
        S_AXI_RREADY = 1'b0;
        tests_run++;
        if (beats !== 256) begin
            failed++; $display("FAIL lr_beats: got %0d beats expected 256", beats);
        end
        tests_run++;
        if (last_err !== 0 || id_err !== 0) begin
            failed++; $display("FAIL lr_rlast_rid: %0d rlast errors, %0d rid errors, expected 0", last_err, id_err);
        end
        tests_run++;
        if (hold_err !== 0) begin
            failed++; $display("FAIL lr_stall_hold: %0d unstable stalled beats expected 0", hold_err);
        end
    endtask

    task automatic test_early_w();
        int w_sent = 0, b_cnt = 0, early_ready = 0, bid_err = 0;
        logic aw_done = 1'b0;
        S_AXI_BREADY = 1'b1;
        for (int cyc = 0; cyc < 40; cyc++) begin
            @(negedge clk);
            if (!aw_done && S_AXI_WREADY) early_ready++;
            if (S_AXI_BVALID) begin
                b_cnt++;
                if (S_AXI_BID !== 4'd9) bid_err++;
            end
            S_AXI_WVALID  = (w_sent < 3);
            S_AXI_WLAST   = (w_sent == 2);
            S_AXI_AWVALID = (cyc >= 4) && !aw_done;
            S_AXI_AWID    = 4'd9;
            if (S_AXI_AWVALID && S_AXI_AWREADY) aw_done = 1'b1;
            if (S_AXI_WVALID && S_AXI_WREADY) w_sent++;
        end
        {S_AXI_AWVALID, S_AXI_WVALID, S_AXI_WLAST, S_AXI_BREADY} = '0;
        tests_run++;
        if (early_ready !== 0) begin
            failed++; $display("FAIL ew_held_off: wready high %0d cycles before AW, expected 0", early_ready);
        end
        tests_run++;
        if (w_sent !== 3) begin
            failed++; $display("FAIL ew_beats: %0d beats accepted expected 3", w_sent);
        end
        tests_run++;
        if (b_cnt !== 1 || bid_err !== 0) begin
            failed++; $display("FAIL ew_bresp: %0d B responses (%0d bad bid) expected 1 with bid 9", b_cnt, bid_err);
        end
    endtask

    task automatic test_concurrent();
        int w_sent = 0, b_wait = 0, b_cnt = 0, bid_err = 0;
        int r_beats = 0, r_first = -1, r_gap = 0, r_last_err = 0;
        S_AXI_AWVALID = 1'b1; S_AXI_AWID = 4'd2;
        S_AXI_ARVALID = 1'b1; S_AXI_ARID = 4'd7; S_AXI_ARLEN = 8'd15;
        S_AXI_RREADY = 1'b1; S_AXI_BREADY = 1'b0;
        for (int cyc = 1; cyc <= 30; cyc++) begin
            @(negedge clk);
            S_AXI_AWVALID = 1'b0; S_AXI_ARVALID = 1'b0;
            S_AXI_WVALID = (w_sent < 8);
            S_AXI_WLAST  = (w_sent == 7);
            if (S_AXI_WVALID && S_AXI_WREADY) w_sent++;
            if (S_AXI_BVALID) begin
                if (b_wait < 5) begin
                    S_AXI_BREADY = 1'b0; b_wait++;
                end else begin
                    S_AXI_BREADY = 1'b1; b_cnt++;
                    if (S_AXI_BID !== 4'd2) bid_err++;
                end
            end else begin
                S_AXI_BREADY = 1'b0;
            end
            if (S_AXI_RVALID) begin
                if (r_beats == 0) r_first = cyc;
                r_beats++;
                if (S_AXI_RLAST !== (r_beats == 16)) r_last_err++;
            end else if (r_beats > 0 && r_beats < 16) begin
                r_gap++;
            end
        end
        {S_AXI_WVALID, S_AXI_WLAST, S_AXI_BREADY, S_AXI_RREADY} = '0;
        tests_run++;
        if (r_beats !== 16 || r_first !== 1 || r_gap !== 0 || r_last_err !== 0) begin
            failed++; $display("FAIL cc_read: beats=%0d first=%0d gaps=%0d rlast_err=%0d expected 16/1/0/0",
                r_beats, r_first, r_gap, r_last_err);
        end
        tests_run++;
        if (w_sent !== 8) begin
            failed++; $display("FAIL cc_wbeats: %0d beats accepted expected 8", w_sent);
        end
        tests_run++;
        if (b_wait !== 5 || b_cnt !== 1 || bid_err !== 0) begin
            failed++; $display("FAIL cc_bresp: held=%0d completed=%0d bad_bid=%0d expected 5/1/0",
                b_wait, b_cnt, bid_err);
        end
    endtask

    task automatic test_reset_mid();
        int stray = 0;
        S_AXI_AWVALID = 1'b1; S_AXI_AWID = 4'd4;
        S_AXI_ARVALID = 1'b1; S_AXI_ARID = 4'd5; S_AXI_ARLEN = 8'd7;
        S_AXI_RREADY = 1'b1; S_AXI_BREADY = 1'b1;
        @(negedge clk);
        S_AXI_AWVALID = 1'b0; S_AXI_ARVALID = 1'b0;
        S_AXI_WVALID = 1'b1; S_AXI_WLAST = 1'b0;
        @(negedge clk);
        tests_run++;
        if ({S_AXI_RVALID, S_AXI_WREADY} !== 2'b11) begin
            failed++; $display("FAIL rm_in_flight: rvalid/wready=%b expected 11", {S_AXI_RVALID, S_AXI_WREADY});
        end
        i_reset = 1'b1;
        @(negedge clk);
        tests_run++;
        if ({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BVALID, S_AXI_ARREADY, S_AXI_RVALID,
             S_AXI_RLAST, S_AXI_BID, S_AXI_RID} !== '0) begin
            failed++; $display("FAIL rm_outputs_zero: some output nonzero after mid-burst reset, expected all 0");
        end
        i_reset = 1'b0; S_AXI_WVALID = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (S_AXI_RVALID || S_AXI_BVALID) stray++;
        end
        tests_run++;
        if (stray !== 0 || S_AXI_ARREADY !== 1'b1 || S_AXI_AWREADY !== 1'b1) begin
            failed++; $display("FAIL rm_idle: %0d stray responses, arready=%b awready=%b expected 0/1/1",
                stray, S_AXI_ARREADY, S_AXI_AWREADY);
        end
        S_AXI_ARVALID = 1'b1; S_AXI_ARID = 4'd6; S_AXI_ARLEN = 8'd0;
        @(negedge clk);
        S_AXI_ARVALID = 1'b0;
        tests_run++;
        if ({S_AXI_RVALID, S_AXI_RLAST} !== 2'b11 || S_AXI_RID !== 4'd6) begin
            failed++; $display("FAIL rm_single_read: rvalid/rlast=%b rid=%0d expected 11/6",
                {S_AXI_RVALID, S_AXI_RLAST}, S_AXI_RID);
        end
        @(negedge clk);
        tests_run++;
        if ({S_AXI_RVALID, S_AXI_RLAST, S_AXI_ARREADY} !== 3'b001) begin
            failed++; $display("FAIL rm_single_done: rvalid/rlast/arready=%b expected 001",
                {S_AXI_RVALID, S_AXI_RLAST, S_AXI_ARREADY});
        end
        {S_AXI_RREADY, S_AXI_BREADY} = '0;
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_read_burst();
        test_long_read();
        test_early_w();
        test_concurrent();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, failed);
        $finish;
    end

endmodule
